// File: rtl/wb_stage.sv
// Registered write-back stage: selects ALU / load / PC+4 / immediate results and
// waits on a variable-latency LSU response for loads, with flush and load timeout.
module wb_stage #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int LD_TIMEOUT = 16,
  localparam int AW        = $clog2(NREG),
  localparam int OW        = $clog2(XLEN / 8)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [1:0]      wb_sel_i,
  input  logic [XLEN-1:0] alu_data_i,
  input  logic [XLEN-1:0] pc_four_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [AW-1:0]   rd_addr_i,
  input  logic            rd_wren_i,
  input  logic [1:0]      ld_size_i,
  input  logic            ld_unsigned_i,
  input  logic [OW-1:0]   ld_offset_i,
  input  logic            ld_valid_i,
  input  logic [XLEN-1:0] ld_data_i,
  output logic            rf_wren_o,
  output logic [AW-1:0]   rf_addr_o,
  output logic [XLEN-1:0] rf_data_o,
  output logic            ld_err_o
);

  localparam int CW = (LD_TIMEOUT < 2) ? 1 : $clog2(LD_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = (LD_TIMEOUT == 0) ? '0 : CW'(LD_TIMEOUT - 1);

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_LD  = 2'b01;
  localparam logic [1:0] SEL_PC4 = 2'b10;

  typedef enum logic {S_IDLE, S_WAIT_LD} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   ld_rd_q;
  logic            ld_wren_q;
  logic [1:0]      ld_size_q;
  logic            ld_uns_q;
  logic [OW-1:0]   ld_off_q;
  logic            rf_wren_q;
  logic [AW-1:0]   rf_addr_q;
  logic [XLEN-1:0] rf_data_q;
  logic            ld_err_q;

  logic [XLEN-1:0] wb_data_d;
  logic [XLEN-1:0] ld_data_d;
  logic [OW-1:0]   ld_aoff;
  logic [XLEN-1:0] ld_shift;
  logic            ld_sgn;
  int              ld_msb;

  assign ready_o   = (state_q == S_IDLE) && !rst_i;
  assign rf_wren_o = rf_wren_q;
  assign rf_addr_o = rf_addr_q;
  assign rf_data_o = rf_data_q;
  assign ld_err_o  = ld_err_q;

  always_comb begin
    wb_data_d = imm_i;
    case (wb_sel_i)
      SEL_ALU: wb_data_d = alu_data_i;
      SEL_PC4: wb_data_d = pc_four_i;
      default: wb_data_d = imm_i;
    endcase
  end

  // Align the field down to bit 0, then fill everything above its MSB with the sign or zero.
  always_comb begin
    ld_aoff = '0;
    ld_msb  = XLEN - 1;
    case (ld_size_q)
      2'b00: begin
        ld_aoff = ld_off_q;
        ld_msb  = 7;
      end
      2'b01: begin
        ld_aoff = ld_off_q & ~OW'(1);
        ld_msb  = 15;
      end
      2'b10: begin
        ld_aoff = (XLEN == 64) ? (ld_off_q & ~OW'(3)) : '0;
        ld_msb  = 31;
      end
      default: begin
        ld_aoff = '0;
        ld_msb  = XLEN - 1;
      end
    endcase
    ld_shift  = ld_data_i >> {ld_aoff, 3'b000};
    ld_sgn    = !ld_uns_q && ld_shift[ld_msb];
    ld_data_d = '0;
    for (int i = 0; i < XLEN; i++) begin
      ld_data_d[i] = (i <= ld_msb) ? ld_shift[i] : ld_sgn;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ld_rd_q   <= '0;
      ld_wren_q <= 1'b0;
      ld_size_q <= 2'b00;
      ld_uns_q  <= 1'b0;
      ld_off_q  <= '0;
      rf_wren_q <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      ld_err_q  <= 1'b0;
    end else begin
      rf_wren_q <= 1'b0;
      ld_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (valid_i && !flush_i) begin
            if (wb_sel_i == SEL_LD) begin
              ld_rd_q   <= rd_addr_i;
              ld_wren_q <= rd_wren_i;
              ld_size_q <= ld_size_i;
              ld_uns_q  <= ld_unsigned_i;
              ld_off_q  <= ld_offset_i;
              cnt_q     <= '0;
              state_q   <= S_WAIT_LD;
            end else begin
              rf_addr_q <= rd_addr_i;
              rf_data_q <= wb_data_d;
              rf_wren_q <= rd_wren_i && (rd_addr_i != '0);
            end
          end
        end
        S_WAIT_LD: begin
          // Flush beats a coincident response; a response beats a coincident timeout.
          if (flush_i) begin
            state_q <= S_IDLE;
          end else if (ld_valid_i) begin
            rf_addr_q <= ld_rd_q;
            rf_data_q <= ld_data_d;
            rf_wren_q <= ld_wren_q && (ld_rd_q != '0);
            state_q   <= S_IDLE;
          end else if ((LD_TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
            ld_err_q <= 1'b1;
            state_q  <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Randomized bench for wb_stage (XLEN=32, LD_TIMEOUT=4) against a transaction-level model
// of result selection, load extraction, flush and timeout.
module tb_wb_stage;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int OW   = 2;
  localparam int TO   = 4;

  logic            clk = 1'b0;
  logic            rst_i, flush_i, valid_i, ready_o;
  logic [1:0]      wb_sel_i;
  logic [XLEN-1:0] alu_data_i, pc_four_i, imm_i;
  logic [AW-1:0]   rd_addr_i;
  logic            rd_wren_i;
  logic [1:0]      ld_size_i;
  logic            ld_unsigned_i;
  logic [OW-1:0]   ld_offset_i;
  logic            ld_valid_i;
  logic [XLEN-1:0] ld_data_i;
  logic            rf_wren_o;
  logic [AW-1:0]   rf_addr_o;
  logic [XLEN-1:0] rf_data_o;
  logic            ld_err_o;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(XLEN), .NREG(NREG), .LD_TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .wb_sel_i(wb_sel_i), .alu_data_i(alu_data_i), .pc_four_i(pc_four_i), .imm_i(imm_i),
    .rd_addr_i(rd_addr_i), .rd_wren_i(rd_wren_i), .ld_size_i(ld_size_i),
    .ld_unsigned_i(ld_unsigned_i), .ld_offset_i(ld_offset_i), .ld_valid_i(ld_valid_i),
    .ld_data_i(ld_data_i), .rf_wren_o(rf_wren_o), .rf_addr_o(rf_addr_o),
    .rf_data_o(rf_data_o), .ld_err_o(ld_err_o)
  );

  int n_chk = 0;
  int n_bad = 0;
  logic [AW-1:0]   m_addr;
  logic [XLEN-1:0] m_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference load result: shift the addressed field down, mask, sign-extend arithmetically.
  function automatic logic [XLEN-1:0] ref_ld(input logic [XLEN-1:0] data, input logic [1:0] size,
                                             input logic uns, input logic [OW-1:0] off);
    int bits, bofs;
    longint unsigned v, mask;
    case (size)
      2'd0:    begin bits = 8;  bofs = int'(off); end
      2'd1:    begin bits = 16; bofs = (int'(off) / 2) * 2; end
      default: begin bits = 32; bofs = 0; end
    endcase
    v    = 64'(data) >> (8 * bofs);
    mask = (64'd1 << bits) - 64'd1;
    v    = v & mask;
    if (!uns && v[bits-1]) v = v | ~mask;
    return v[XLEN-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_i = 0; flush_i = 0; ld_valid_i = 0;
    wb_sel_i = 2'($urandom); alu_data_i = $urandom; pc_four_i = $urandom; imm_i = $urandom;
    rd_addr_i = AW'($urandom); rd_wren_i = 1'($urandom); ld_size_i = 2'($urandom);
    ld_unsigned_i = 1'($urandom); ld_offset_i = OW'($urandom); ld_data_i = $urandom;
  endtask

  task automatic do_alu(input logic [1:0] sel, input logic [XLEN-1:0] val,
                        input logic [AW-1:0] rd, input logic we);
    chk("alu_ready", ready_o, 1);
    idle();
    valid_i = 1; wb_sel_i = sel; rd_addr_i = rd; rd_wren_i = we;
    case (sel)
      2'b00:   alu_data_i = val;
      2'b10:   pc_four_i = val;
      default: imm_i = val;
    endcase
    step();
    idle();
    m_addr = rd; m_data = val;
    chk("alu_wren", rf_wren_o, 64'(we && rd != 0));
    chk("alu_addr", rf_addr_o, m_addr);
    chk("alu_data", rf_data_o, m_data);
    chk("alu_err", ld_err_o, 0);
  endtask

  task automatic accept_load(input logic [1:0] size, input logic uns, input logic [OW-1:0] off,
                             input logic [AW-1:0] rd, input logic we);
    chk("ld_acc_ready", ready_o, 1);
    idle();
    valid_i = 1; wb_sel_i = 2'b01; ld_size_i = size; ld_unsigned_i = uns;
    ld_offset_i = off; rd_addr_i = rd; rd_wren_i = we;
    step();
    idle();
    chk("ld_acc_wren", rf_wren_o, 0);
    chk("ld_acc_ready", ready_o, 0);
  endtask

  task automatic do_load(input logic [XLEN-1:0] data, input logic [1:0] size, input logic uns,
                         input logic [OW-1:0] off, input logic [AW-1:0] rd, input logic we,
                         input int dly, input logic fl);
    accept_load(size, uns, off, rd, we);
    for (int i = 1; i < dly; i++) begin
      step();
      idle();
      chk("ld_wait_wren", rf_wren_o, 0);
      chk("ld_wait_ready", ready_o, 0);
      chk("ld_wait_err", ld_err_o, 0);
    end
    ld_valid_i = 1; ld_data_i = data; flush_i = fl;
    step();
    idle();
    if (!fl) begin
      m_addr = rd; m_data = ref_ld(data, size, uns, off);
    end
    chk("ld_wren", rf_wren_o, 64'(!fl && we && rd != 0));
    chk("ld_addr", rf_addr_o, m_addr);
    chk("ld_data", rf_data_o, m_data);
    chk("ld_err", ld_err_o, 0);
    chk("ld_ready", ready_o, 1);
  endtask

  task automatic do_timeout(input logic [AW-1:0] rd);
    accept_load(2'b10, 1'b0, '0, rd, 1'b1);
    for (int k = 1; k <= TO; k++) begin
      step();
      idle();
      chk("to_wren", rf_wren_o, 0);
      chk("to_err", ld_err_o, 64'(k == TO));
      chk("to_ready", ready_o, 64'(k == TO));
    end
    chk("to_hold_addr", rf_addr_o, m_addr);
    chk("to_hold_data", rf_data_o, m_data);
    step();
    chk("to_err_once", ld_err_o, 0);
  endtask

  task automatic do_flush_idle();
    chk("fi_ready", ready_o, 1);
    idle();
    valid_i = 1; flush_i = 1; ld_valid_i = 1'($urandom);
    step();
    idle();
    chk("fi_wren", rf_wren_o, 0);
    chk("fi_hold_addr", rf_addr_o, m_addr);
    chk("fi_hold_data", rf_data_o, m_data);
    chk("fi_ready", ready_o, 1);
  endtask

  initial begin
    logic [1:0] sel;
    idle();
    rst_i = 1;
    m_addr = '0; m_data = '0;
    #12;
    chk("rst_ready", ready_o, 0);
    chk("rst_wren", rf_wren_o, 0);
    chk("rst_addr", rf_addr_o, 0);
    chk("rst_data", rf_data_o, 0);
    chk("rst_err", ld_err_o, 0);
    @(negedge clk);
    rst_i = 0;
    #1;
    chk("rel_ready", ready_o, 1);

    do_alu(2'b00, 32'h1234_5678, 5'd5, 1'b1);
    do_alu(2'b10, 32'h0000_0104, 5'd6, 1'b1);
    do_alu(2'b11, 32'hCAFE_0001, 5'd7, 1'b1);

    do_load(32'h80FF_0000, 2'b00, 1'b0, 2'd3, 5'd8, 1'b1, 3, 1'b0);
    chk("lb_val", rf_data_o, 32'hFFFF_FF80);
    do_load(32'h80FF_0000, 2'b00, 1'b1, 2'd3, 5'd9, 1'b1, 3, 1'b0);
    chk("lbu_val", rf_data_o, 32'h0000_0080);
    do_load(32'h8001_0000, 2'b01, 1'b0, 2'd2, 5'd10, 1'b1, 3, 1'b0);
    chk("lh_val", rf_data_o, 32'hFFFF_8001);

    do_alu(2'b00, 32'h5555_AAAA, 5'd0, 1'b1);
    do_load(32'h1234_5678, 2'b10, 1'b0, 2'd0, 5'd0, 1'b1, 2, 1'b0);

    do_load(32'h7777_7777, 2'b10, 1'b0, 2'd0, 5'd11, 1'b1, 2, 1'b1);

    do_timeout(5'd12);
    do_load(32'h8765_4321, 2'b10, 1'b0, 2'd0, 5'd13, 1'b1, TO, 1'b0);

    // Reset asserted mid-WAIT_LD with nonzero outputs, then a stray response after release.
    accept_load(2'b00, 1'b0, 2'd1, 5'd14, 1'b1);
    step();
    #2 rst_i = 1;
    #1;
    chk("mid_rst_wren", rf_wren_o, 0);
    chk("mid_rst_addr", rf_addr_o, 0);
    chk("mid_rst_data", rf_data_o, 0);
    chk("mid_rst_err", ld_err_o, 0);
    chk("mid_rst_ready", ready_o, 0);
    @(negedge clk);
    rst_i = 0;
    #1;
    chk("mid_rel_ready", ready_o, 1);
    m_addr = '0; m_data = '0;
    ld_valid_i = 1; ld_data_i = $urandom;
    step();
    idle();
    chk("late_ld_wren", rf_wren_o, 0);
    chk("late_ld_err", ld_err_o, 0);
    chk("late_ld_ready", ready_o, 1);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          sel = 2'($urandom);
          if (sel == 2'b01) sel = 2'b00;
          do_alu(sel, $urandom, AW'($urandom), 1'($urandom));
        end
        3, 4, 5, 6:
          do_load($urandom, 2'($urandom), 1'($urandom), OW'($urandom), AW'($urandom),
                  1'($urandom), $urandom_range(1, TO), ($urandom_range(0, 7) == 0));
        7: do_timeout(AW'($urandom));
        default: do_flush_idle();
      endcase
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1, "watchdog");
  end
endmodule
